// File: rtl/silly_function_pkg.sv
// Shared constants and types for the silly_function glue block.
// Index layout is {a,b,c} with a as the MSB.
package silly_function_pkg;

    localparam int IDX_W        = 3;
    localparam int NUM_MINTERMS = 8;

    // Default gives y = ~b & (a | ~c): ones at indices 0, 4 and 5.
    localparam logic [NUM_MINTERMS-1:0] DEFAULT_TRUTH_TABLE = 8'h31;

    typedef logic [IDX_W-1:0] sf_idx_t;

endpackage

// File: rtl/sf_decode3to8.sv
// One-hot decode of a 3-bit index into eight minterm lines.
// An unknown index drives every line unknown rather than a partial decode.
module sf_decode3to8
    import silly_function_pkg::*;
(
    input  logic [2:0] idx,
    output logic [7:0] minterm
);

    sf_idx_t idx_t;
    logic    x_taint;

    assign idx_t = sf_idx_t'(idx);

    // Constant 0 for known inputs; X whenever any index bit is X/Z, so the
    // whole decode goes unknown instead of only the ambiguous lines.
    assign x_taint = (^idx_t) ^ (^idx_t);

    generate
        for (genvar gi = 0; gi < NUM_MINTERMS; gi++) begin : g_line
            assign minterm[gi] = (idx_t == sf_idx_t'(gi)) ^ x_taint;
        end
    endgenerate

endmodule

// File: rtl/silly_function.sv
// Three-input table-driven Boolean function with registered copy and minterm decode.
// Define SILLY_FUNCTION_STATS_EN to add the saturating hit_cnt output.
module silly_function
    import silly_function_pkg::*;
#(
    parameter logic [7:0] TRUTH_TABLE = DEFAULT_TRUTH_TABLE,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             y,
    output logic             y_q,
    output logic [7:0]       minterm
`ifdef SILLY_FUNCTION_STATS_EN
    ,
    output logic [CNT_W-1:0] hit_cnt
`endif
);

    logic [IDX_W-1:0] idx;
    logic [7:0]       tt_hits;
    logic             y_q_reg;
    logic             y_q_next;

    assign idx = {a, b, c};

    sf_decode3to8 u_decode (
        .idx     (idx),
        .minterm (minterm)
    );

    // Table lookup through the decode keeps y purely combinational and lets
    // unknown inputs propagate straight to the output.
    generate
        for (genvar gi = 0; gi < NUM_MINTERMS; gi++) begin : g_tt
            assign tt_hits[gi] = minterm[gi] & TRUTH_TABLE[gi];
        end
    endgenerate

    assign y = |tt_hits;

    always_comb begin
        y_q_next = y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q_reg <= 1'b0;
        end else begin
            y_q_reg <= y_q_next;
        end
    end

    assign y_q = y_q_reg;

`ifdef SILLY_FUNCTION_STATS_EN
    logic [CNT_W-1:0] hit_cnt_reg;
    logic [CNT_W-1:0] hit_cnt_next;

    // Saturates at all-ones so a long-running count never wraps to a small value.
    always_comb begin
        hit_cnt_next = hit_cnt_reg;
        if (y && (hit_cnt_reg != {CNT_W{1'b1}})) begin
            hit_cnt_next = hit_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_reg <= '0;
        end else begin
            hit_cnt_reg <= hit_cnt_next;
        end
    end

    assign hit_cnt = hit_cnt_reg;
`else
    logic [CNT_W-1:0] stats_unused;
    assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_silly_function.sv
// Self-checking bench for silly_function: exhaustive combinational sweep,
// reset/latency scenarios, random traffic and (with the stats macro) the counter.
module tb_silly_function;

    logic       clk;
    logic       reset;
    logic       a, b, c;
    logic       y, y_q;
    logic [7:0] minterm;
    logic       y_tt, y_q_tt;
    logic [7:0] minterm_tt;
`ifdef SILLY_FUNCTION_STATS_EN
    logic [3:0] hit_cnt;
    logic [3:0] hit_cnt_tt;
`endif

    int n_checks;
    int n_pass;
    int exp_q[$];
    int cnt_model;

    silly_function #(.CNT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .c       (c),
        .y       (y),
        .y_q     (y_q),
        .minterm (minterm)
`ifdef SILLY_FUNCTION_STATS_EN
        ,
        .hit_cnt (hit_cnt)
`endif
    );

    silly_function #(.TRUTH_TABLE(8'h80), .CNT_W(4)) dut_tt (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .c       (c),
        .y       (y_tt),
        .y_q     (y_q_tt),
        .minterm (minterm_tt)
`ifdef SILLY_FUNCTION_STATS_EN
        ,
        .hit_cnt (hit_cnt_tt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference written from the Boolean form, not from a table lookup.
    function automatic logic model_y(input int idx);
        logic ma, mb, mc;
        ma = idx[2];
        mb = idx[1];
        mc = idx[0];
        return ~mb & (ma | ~mc);
    endfunction

    task automatic drive_cycle(input int idx, input logic rst);
        int exp_y_q;
        int got_exp;
        @(negedge clk);
        {a, b, c} = idx[2:0];
        reset = rst;
        #1;
        check("y_comb", {31'b0, y}, {31'b0, model_y(idx)});
        exp_y_q = rst ? 0 : int'(model_y(idx));
        exp_q.push_back(exp_y_q);
        if (rst) begin
            cnt_model = 0;
        end else if (model_y(idx) && cnt_model != 15) begin
            cnt_model++;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got_exp = exp_q.pop_front();
            $display("cycle idx=%0d rst=%0d y_q=%0d exp=%0d", idx, rst, y_q, got_exp);
            check("y_q", {31'b0, y_q}, got_exp);
        end
`ifdef SILLY_FUNCTION_STATS_EN
        check("hit_cnt", {28'b0, hit_cnt}, cnt_model);
`endif
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        cnt_model = 0;
        reset     = 1'b1;
        {a, b, c} = 3'b000;

        // Exhaustive combinational sweep, both truth tables.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] onehot;
            {a, b, c} = 3'(i);
            #10;
            onehot = 8'h01 << i;
            $display("comb idx=%0d y=%0d minterm=%02h y_tt=%0d", i, y, minterm, y_tt);
            check("sweep_y", {31'b0, y}, {31'b0, model_y(i)});
            check("sweep_minterm", {24'b0, minterm}, {24'b0, onehot});
            check("sweep_y_tt", {31'b0, y_tt}, (i == 7) ? 32'd1 : 32'd0);
        end

        // Reset held for two edges with 000: y stays 1, y_q held at 0.
        drive_cycle(0, 1'b1);
        drive_cycle(0, 1'b1);
        check("reset_y_q_tt", {31'b0, y_q_tt}, 32'd0);
        drive_cycle(0, 1'b0);

        // Latency: 100 -> 110.
        drive_cycle(4, 1'b0);
        drive_cycle(4, 1'b0);
        drive_cycle(6, 1'b0);

        // Mid-run reset, released with 101.
        drive_cycle(5, 1'b0);
        drive_cycle(5, 1'b1);
        drive_cycle(5, 1'b0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 30; i++) begin
            drive_cycle(int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
        end

        // Counter saturation then clear.
        drive_cycle(0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(0, 1'b0);
        end
`ifdef SILLY_FUNCTION_STATS_EN
        check("hit_cnt_sat", {28'b0, hit_cnt}, 32'hF);
`endif
        drive_cycle(0, 1'b1);
`ifdef SILLY_FUNCTION_STATS_EN
        check("hit_cnt_clr", {28'b0, hit_cnt}, 32'h0);
`endif

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
